uart_inst_rx: RTL and testbench
===============================

Name: uart_inst_rx

Overview:
- Serial receive front end for the sequencer on the RsRx pin: the other end of the link the bench UART model drives.
- Deserialises 8N1 UART frames (LSB first) into 8-bit instruction words.
- Presents each word on inst_wd with a single-cycle inst_vld strobe, in the same form the switch/button path delivers to the sequencer core.
- Sits in nexys3 between the RsRx pin and the instruction mux.

Parameters:
- CLKS_PER_BIT, 100, clk cycles per bit period (100 MHz / 1 Mbaud); legal range is 4 or more.
- HALF_BIT, CLKS_PER_BIT/2, cycles from the detected start edge to the start-bit mid-sample.

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  synchronous active-low reset
- rx  input  1  asynchronous serial line, idle high
- inst_wd  output  8  last correctly framed byte received
- inst_vld  output  1  one-cycle strobe: inst_wd was updated this cycle
- frame_err  output  1  one-cycle strobe: stop bit sampled low
- busy  output  1  high while a frame is in progress (any state except IDLE)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Synchroniser: two-flop synchroniser on rx, both flops reset to 1. The FSM uses only the synchronised value rx_s.
- Values while rst_n is low:
  - inst_wd = 8'h00, inst_vld = 0, frame_err = 0, busy = 0.
  - FSM = IDLE; bit counter, cycle counter and shift register cleared.
- Reset asserted mid-frame aborts the frame. No inst_vld or frame_err is produced, and inst_wd is unchanged from its reset value.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. The cycle counter is cnt.
- IDLE:
  - If rx_s == 0: go to START with cnt = 0.
  - Otherwise stay in IDLE.
- START:
  - cnt increments each cycle.
  - At cnt == HALF_BIT-1, sample rx_s.
  - If rx_s is 0: go to DATA with cnt = 0 and bit index = 0.
  - If rx_s is 1 (a glitch): return to IDLE with no strobe.
- DATA:
  - At cnt == CLKS_PER_BIT-1, shift rx_s into bit position [bit index] (LSB first), clear cnt, and increment bit index.
  - After bit 7 is stored, go to STOP.
- STOP: at cnt == CLKS_PER_BIT-1, sample rx_s.
  - rx_s = 1: the next cycle drives inst_wd with the shift register and inst_vld = 1 for exactly one cycle. Then go to IDLE.
  - rx_s = 0: frame_err = 1 for exactly one cycle and inst_wd is unchanged. Then go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s == 1, then go to IDLE. A line held low (break) therefore yields exactly one frame_err and no spurious frames.
- Sampling points:
  - All data and stop samples land at bit centres (start edge + HALF_BIT + k*CLKS_PER_BIT).
  - Returning to IDLE at the stop-bit centre means a start bit that immediately follows a stop bit is detected. Back-to-back frames need no idle gap.
- Latency: inst_vld asserts 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the rx falling edge, within ±1 cycle of synchroniser phase. With the defaults this is 953 ±1 cycles.
- inst_vld and frame_err are never high in the same cycle.
- inst_wd holds its value between strobes.

Test Plan:
- Reset, then rx idle high for 10 µs: inst_vld = 0, frame_err = 0, busy = 0, inst_wd = 8'h00.
- Send byte 8'b00000100 (PUSH r0,4) at 1 Mbaud: exactly one inst_vld pulse, 953 ±1 cycles after the start edge, with inst_wd = 8'h04. busy is high throughout the frame.
- Send 8'h67 then 8'hF0 back-to-back, with no gap after the stop bit: two inst_vld pulses about 1000 cycles apart, carrying inst_wd = 8'h67 then 8'hF0.
- Drive rx low for 20 cycles, then high: busy pulses, and there is no inst_vld and no frame_err.
- Send 8'hA5 with the stop bit forced low, then hold rx low for 3 bit times, then release:
  - exactly one frame_err pulse;
  - inst_wd keeps its previous value;
  - the next valid frame 8'h3C is received correctly.
- Send 8'hC0 and assert rst_n = 0 for 2 cycles during data bit 4: no strobe for that frame, inst_wd = 8'h00, and the subsequent frame 8'h81 is received correctly.

Source files
------------

// File: rtl/uart_inst_rx.sv
// uart_inst_rx: 8N1 UART receiver between the RsRx pin and the instruction mux.
// Each correctly framed byte appears on inst_wd with a one-cycle inst_vld strobe.
// A stop bit sampled low raises a one-cycle frame_err and leaves inst_wd untouched.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | qualifying the start bit at its centre (rejects glitches)
// DATA      | sampling eight data bits at bit centres, LSB first
// STOP      | sampling the stop bit at its centre
// WAIT_IDLE | stop bit was low (break/framing error); wait for line high
module uart_inst_rx #(
  parameter int CLKS_PER_BIT = 100,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] inst_wd,
  output logic       inst_vld,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             rx_m;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  logic             cnt_clr;
  logic             cnt_run;
  logic             data_tick;
  logic             start_ok;
  logic             stop_ok;
  logic             stop_bad;

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; returning to IDLE at the stop centre allows back-to-back frames.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (!rx_s) state_nx = START;
      end
      START: begin
        if (cnt == HALF_LAST) state_nx = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if ((cnt == BIT_LAST) && (bit_idx == 3'd7)) state_nx = STOP;
      end
      STOP: begin
        if (cnt == BIT_LAST) state_nx = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Per-state control decode driving the datapath below.
  always_comb begin
    busy      = (state != IDLE);
    cnt_run   = (state == START) || (state == DATA) || (state == STOP);
    data_tick = (state == DATA) && (cnt == BIT_LAST);
    start_ok  = (state == START) && (cnt == HALF_LAST) && !rx_s;
    stop_ok   = (state == STOP) && (cnt == BIT_LAST) && rx_s;
    stop_bad  = (state == STOP) && (cnt == BIT_LAST) && !rx_s;
    cnt_clr   = (state_nx != state) || data_tick;
  end

  // Bit-period counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      if (cnt_clr || !cnt_run) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (start_ok) begin
        bit_idx <= 3'd0;
      end else if (data_tick) begin
        shreg[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end
    end
  end

  // Registered result strobes; inst_wd only moves on a good stop bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_wd   <= 8'h00;
      inst_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      inst_vld  <= stop_ok;
      frame_err <= stop_bad;
      if (stop_ok) inst_wd <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_inst_rx.sv
// tb_uart_inst_rx: directed frames against uart_inst_rx at CLKS_PER_BIT = 100.
module tb_uart_inst_rx;

  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] inst_wd;
  logic       inst_vld;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  int cyc = 0;
  int start_cyc = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int busy_miss = 0;
  bit busy_seen = 1'b0;
  bit busy_mon = 1'b0;
  logic [7:0] data_q[$];
  int cyc_q[$];

  uart_inst_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .inst_wd   (inst_wd),
    .inst_vld  (inst_vld),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (inst_vld) begin
      vld_cnt++;
      data_q.push_back(inst_wd);
      cyc_q.push_back(cyc);
    end
    if (frame_err) err_cnt++;
    if (inst_vld && frame_err) both_cnt++;
    if (busy) busy_seen = 1'b1;
    if (busy_mon && !busy) busy_miss++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 10-bit frame: start, 8 data bits LSB first, stop. Line is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    int fc;
    bits = {stop, d, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        fc = i * CPB + k + 1;
        busy_mon = (fc >= 5) && (fc <= 945);
      end
    end
    busy_mon = 1'b0;
  endtask

  int v0, e0, lat, gap;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);

    // idle line after reset
    chk("rst_wd",    inst_wd,   8'h00);
    chk("rst_vld",   inst_vld,  1'b0);
    chk("rst_ferr",  frame_err, 1'b0);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_nvld",  vld_cnt,   0);
    chk("rst_nerr",  err_cnt,   0);
    chk("rst_bseen", busy_seen, 1'b0);

    // single frame 0x04 with latency and busy coverage
    v0 = vld_cnt;
    busy_miss = 0;
    send_frame(8'h04, 1'b1);
    repeat (20) @(negedge clk);
    chk("f04_count", vld_cnt - v0, 1);
    chk("f04_wd", inst_wd, 8'h04);
    lat = (cyc_q.size() > 0) ? cyc_q[$] - start_cyc + 1000 + 20 - 1000 - 20 : -1;
    lat = (cyc_q.size() > 0) ? cyc_q[$] - (cyc - 1020) : -1;
    chk("f04_latency_in_953pm1", (lat >= 952) && (lat <= 954), 1'b1);
    chk("f04_busy_in_frame", busy_miss, 0);
    chk("f04_busy_after", busy, 1'b0);

    // back-to-back 0x67, 0xF0 with no idle gap
    data_q.delete();
    cyc_q.delete();
    v0 = vld_cnt;
    send_frame(8'h67, 1'b1);
    send_frame(8'hF0, 1'b1);
    repeat (50) @(negedge clk);
    chk("b2b_count", vld_cnt - v0, 2);
    if (data_q.size() == 2) begin
      chk("b2b_first", data_q[0], 8'h67);
      chk("b2b_second", data_q[1], 8'hF0);
      gap = cyc_q[1] - cyc_q[0];
      chk("b2b_spacing", (gap >= 999) && (gap <= 1001), 1'b1);
    end
    chk("b2b_wd_hold", inst_wd, 8'hF0);

    // 20-cycle low glitch
    v0 = vld_cnt;
    e0 = err_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_busy_pulse", busy_seen, 1'b1);
    chk("glitch_no_vld", vld_cnt - v0, 0);
    chk("glitch_no_ferr", err_cnt - e0, 0);
    chk("glitch_busy_end", busy, 1'b0);

    // 0xA5 with low stop bit, then break of 3 bit times
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame(8'hA5, 1'b0);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    chk("ferr_count", err_cnt - e0, 1);
    chk("ferr_no_vld", vld_cnt - v0, 0);
    chk("ferr_wd_hold", inst_wd, 8'hF0);
    chk("ferr_busy_end", busy, 1'b0);
    v0 = vld_cnt;
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    chk("after_ferr_count", vld_cnt - v0, 1);
    chk("after_ferr_wd", inst_wd, 8'h3C);

    // reset pulse during data bit 4 of 0xC0
    v0 = vld_cnt;
    e0 = err_cnt;
    fork
      send_frame(8'hC0, 1'b1);
      begin
        repeat (5 * CPB + 50) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    chk("rst_mid_no_vld", vld_cnt - v0, 0);
    chk("rst_mid_no_ferr", err_cnt - e0, 0);
    chk("rst_mid_wd", inst_wd, 8'h00);
    // The rest of the aborted frame can be picked up as a new start edge after
    // reset releases; let the line idle long enough for that to drain.
    rx = 1'b1;
    repeat (1500) @(negedge clk);
    v0 = vld_cnt;
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    chk("after_rst_count", vld_cnt - v0, 1);
    chk("after_rst_wd", inst_wd, 8'h81);

    chk("never_vld_and_ferr", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
